// File: rtl/cpu_types_pkg.sv
// Shared RV32I types for the multicycle control path: opcodes, branch codes,
// sequencer states, ALU operations and the decoded control bundle.
package cpu_types_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_ITYPE  = 7'b0010011,
        OP_RTYPE  = 7'b0110011
    } opcode_t;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_t;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} mc_state_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB,
        ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    localparam logic [31:0] HALT_INSTR = 32'hFFFFFFFF;

    typedef struct packed {
        aluop_t alu_op;
        logic   alusrc;
        logic   memtoreg;
        logic   jal;
        logic   jalr;
        logic   auipc;
        logic   lui;
        logic   is_load;
        logic   is_store;
        logic   is_branch;
        logic   br_ne;       // branch taken when the ALU result is nonzero
        logic   illegal;
        logic   halt_instr;
    } ctrl_t;

    function automatic aluop_t alu_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Port bundle of the multicycle control unit, with control-unit and bench views.
interface multicycle_control_unit_if
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input logic CLK
);
    logic              RST;
    logic [WORD_W-1:0] imemload;
    logic              ihit, dhit, zero;
    logic              iREN, dREN, dWEN;
    logic              ir_en, pc_en, WEN;
    aluop_t            alu_op;
    logic              ALUsrc, memtoreg, jal, jalr, auipc, lui, branch_taken;
    logic [WORD_W-1:0] instr;
    logic              halt, illegal, timeout;

    modport cu (
        input  CLK, RST, imemload, ihit, dhit, zero,
        output iREN, dREN, dWEN, ir_en, pc_en, WEN, alu_op, ALUsrc, memtoreg,
               jal, jalr, auipc, lui, branch_taken, instr, halt, illegal, timeout
    );

    modport tb (
        input  CLK, iREN, dREN, dWEN, ir_en, pc_en, WEN, alu_op, ALUsrc, memtoreg,
               jal, jalr, auipc, lui, branch_taken, instr, halt, illegal, timeout,
        output RST, imemload, ihit, dhit, zero
    );
endinterface

// File: rtl/instr_decoder.sv
// Combinational RV32I decode of the instruction register into the control bundle.
module instr_decoder
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] instr,
    output ctrl_t             ctrl
);
    opcode_t    op;
    logic [2:0] f3;

    assign op = opcode_t'(instr[6:0]);
    assign f3 = instr[14:12];

    always_comb begin
        ctrl            = '0;
        ctrl.alu_op     = ALU_ADD;
        ctrl.halt_instr = (instr == WORD_W'(HALT_INSTR));
        case (op)
            OP_LUI:   begin ctrl.lui   = 1'b1; ctrl.alusrc = 1'b1; end
            OP_AUIPC: begin ctrl.auipc = 1'b1; ctrl.alusrc = 1'b1; end
            OP_JAL:   begin ctrl.jal   = 1'b1; ctrl.alusrc = 1'b1; end
            OP_JALR:  begin ctrl.jalr  = 1'b1; ctrl.alusrc = 1'b1; end
            OP_LOAD: begin
                ctrl.is_load  = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            OP_STORE: begin ctrl.is_store = 1'b1; ctrl.alusrc = 1'b1; end
            // only shifts use funct7 for immediates; addi never becomes a subtract
            OP_ITYPE: begin
                ctrl.alusrc = 1'b1;
                ctrl.alu_op = alu_f3(f3, instr[30] && (f3 == 3'd5));
            end
            OP_RTYPE: ctrl.alu_op = alu_f3(f3, instr[30]);
            OP_BRANCH: begin
                ctrl.is_branch = 1'b1;
                case (f3)
                    F3_BLT, F3_BGE:   ctrl.alu_op = ALU_SLT;
                    F3_BLTU, F3_BGEU: ctrl.alu_op = ALU_SLTU;
                    default:          ctrl.alu_op = ALU_SUB;
                endcase
                ctrl.br_ne = (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BLTU);
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I sequencer: instruction register, FETCH..HALT state machine and
// per-state datapath enables. Define CU_WATCHDOG_EN to add the memory-wait watchdog.
module multicycle_control_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] imemload,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              zero,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              ir_en,
    output logic              pc_en,
    output logic              WEN,
    output aluop_t            alu_op,
    output logic              ALUsrc,
    output logic              memtoreg,
    output logic              jal,
    output logic              jalr,
    output logic              auipc,
    output logic              lui,
    output logic              branch_taken,
    output logic [WORD_W-1:0] instr,
    output logic              halt,
    output logic              illegal,
    output logic              timeout
);
    mc_state_t state;
    ctrl_t     dec;
    logic      wd_fire;
    logic      ctrl_on;

    instr_decoder #(.WORD_W(WORD_W)) u_dec (
        .instr (instr),
        .ctrl  (dec)
    );

    // decoded bundle is presented from DECODE until the instruction retires
    assign ctrl_on = !RST && (state inside {DECODE, EXEC, MEM, WB});

    always_comb begin
        iREN         = 1'b0;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        WEN          = 1'b0;
        branch_taken = 1'b0;
        alu_op       = ctrl_on ? dec.alu_op : aluop_t'(4'd0);
        ALUsrc       = ctrl_on && dec.alusrc;
        memtoreg     = ctrl_on && dec.memtoreg;
        jal          = ctrl_on && dec.jal;
        jalr         = ctrl_on && dec.jalr;
        auipc        = ctrl_on && dec.auipc;
        lui          = ctrl_on && dec.lui;
        if (!RST) begin
            case (state)
                FETCH: begin
                    iREN  = 1'b1;
                    ir_en = ihit;
                end
                EXEC: if (dec.is_branch) begin
                    pc_en        = 1'b1;
                    branch_taken = dec.br_ne ? !zero : zero;
                end
                MEM: begin
                    dREN  = dec.is_load;
                    dWEN  = dec.is_store;
                    pc_en = dec.is_store && dhit;
                end
                WB: begin
                    WEN   = 1'b1;
                    pc_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= FETCH;
            instr   <= '0;
            halt    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH:
                    if (ihit) begin
                        instr <= imemload;
                        state <= DECODE;
                    end else if (wd_fire) begin
                        state <= HALT;
                        halt  <= 1'b1;
                    end
                DECODE:
                    if (dec.halt_instr) begin
                        state <= HALT;
                        halt  <= 1'b1;
                    end else if (dec.illegal) begin
                        state   <= HALT;
                        halt    <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        state <= EXEC;
                    end
                EXEC:
                    if (dec.is_load || dec.is_store) state <= MEM;
                    else if (dec.is_branch)          state <= FETCH;
                    else                             state <= WB;
                MEM:
                    if (dhit) begin
                        state <= dec.is_load ? WB : FETCH;
                    end else if (wd_fire) begin
                        state <= HALT;
                        halt  <= 1'b1;
                    end
                WB:      state <= FETCH;
                default: state <= HALT;
            endcase
        end
    end

`ifdef CU_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          waiting;

    // a hit in the limit cycle leaves waiting low, so the hit wins
    assign waiting = ((state == FETCH) && !ihit) || ((state == MEM) && !dhit);
    assign wd_fire = waiting && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                      wait_cnt <= '0;
        else if (waiting && !wd_fire) wait_cnt <= wait_cnt + 1'b1;
        else                          wait_cnt <= '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          timeout <= 1'b0;
        else if (wd_fire) timeout <= 1'b1;
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against a phase-schedule model.
module tb_multicycle_control_unit;
    import cpu_types_pkg::*;

    localparam int TMO = 4;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.WORD_W(32)) bus (.CLK(clk));

    multicycle_control_unit #(.WORD_W(32), .TIMEOUT(TMO)) dut (
        .CLK(clk), .RST(bus.RST), .imemload(bus.imemload), .ihit(bus.ihit),
        .dhit(bus.dhit), .zero(bus.zero), .iREN(bus.iREN), .dREN(bus.dREN),
        .dWEN(bus.dWEN), .ir_en(bus.ir_en), .pc_en(bus.pc_en), .WEN(bus.WEN),
        .alu_op(bus.alu_op), .ALUsrc(bus.ALUsrc), .memtoreg(bus.memtoreg),
        .jal(bus.jal), .jalr(bus.jalr), .auipc(bus.auipc), .lui(bus.lui),
        .branch_taken(bus.branch_taken), .instr(bus.instr), .halt(bus.halt),
        .illegal(bus.illegal), .timeout(bus.timeout)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ir_m;
    logic        h_m, ill_m, to_m;

    logic [6:0] ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    logic [2:0] brf [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [3:0] alu_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic string pname(input int ph);
        case (ph)
            P_F: return "fetch";
            P_D: return "decode";
            P_E: return "exec";
            P_M: return "mem";
            P_W: return "wb";
            default: return "halt";
        endcase
    endfunction

    function automatic logic [19:0] actv();
        return {bus.iREN, bus.dREN, bus.dWEN, bus.ir_en, bus.pc_en, bus.WEN,
                bus.alu_op, bus.ALUsrc, bus.memtoreg, bus.jal, bus.jalr,
                bus.auipc, bus.lui, bus.branch_taken, bus.halt, bus.illegal, bus.timeout};
    endfunction

    // expected outputs for one cycle of a given phase of the instruction in ir
    function automatic logic [19:0] expv(input int ph, input logic [31:0] ir,
                                         input logic ih, input logic dh, input logic z);
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] alu;
        logic ld, st, br, src, m2r, jl, jr, au, lu, tk;
        logic ren, drd, dwr, ie, pe, we, on;
        op = ir[6:0];
        f3 = ir[14:12];
        {ld, st, br, src, m2r, jl, jr, au, lu, ren, drd, dwr, ie, pe, we} = '0;
        alu = ALU_ADD;
        case (op)
            7'b0110111: begin lu = 1; src = 1; end
            7'b0010111: begin au = 1; src = 1; end
            7'b1101111: begin jl = 1; src = 1; end
            7'b1100111: begin jr = 1; src = 1; end
            7'b0000011: begin ld = 1; src = 1; m2r = 1; end
            7'b0100011: begin st = 1; src = 1; end
            7'b0010011: begin
                src = 1;
                alu = alu_tab[f3];
                if (f3 == 3'd5 && ir[30]) alu = ALU_SRA;
            end
            7'b0110011: begin
                alu = alu_tab[f3];
                if (ir[30] && f3 == 3'd0) alu = ALU_SUB;
                if (ir[30] && f3 == 3'd5) alu = ALU_SRA;
            end
            7'b1100011: begin
                br  = 1;
                alu = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
            end
            default: ;
        endcase
        tk = (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) ? z : !z;
        on = (ph == P_D) || (ph == P_E) || (ph == P_M) || (ph == P_W);
        case (ph)
            P_F: begin ren = 1; ie = ih; end
            P_E: pe = br;
            P_M: begin drd = ld; dwr = st; pe = st && dh; end
            P_W: begin we = 1; pe = 1; end
            default: ;
        endcase
        return {ren, drd, dwr, ie, pe, we, on ? alu : 4'd0, on && src, on && m2r,
                on && jl, on && jr, on && au, on && lu, (ph == P_E) && br && tk,
                h_m, ill_m, to_m};
    endfunction

    // entered at posedge+1; checks at negedge; leaves at the next posedge+1
    task automatic step(input int ph, input logic ih, input logic dh, input logic z,
                        input logic [31:0] mem);
        bus.ihit = ih; bus.dhit = dh; bus.zero = z; bus.imemload = mem;
        @(negedge clk);
        chk(pname(ph), {12'd0, actv()}, {12'd0, expv(ph, ir_m, ih, dh, z)});
        chk("instr", bus.instr, ir_m);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus.RST = 1'b1;
        ir_m = '0; h_m = 0; ill_m = 0; to_m = 0;
        bus.ihit = 0; bus.dhit = 0; bus.zero = 0;
        @(negedge clk);
        chk("reset_out", {12'd0, actv()}, 32'd0);
        chk("reset_instr", bus.instr, 32'd0);
        @(posedge clk); #1;
        bus.RST = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic z);
        logic [6:0] op;
        op = ins[6:0];
        for (int i = 0; i <= iw; i++) begin
`ifdef CU_WATCHDOG_EN
            if (i == TMO) begin
                h_m = 1; to_m = 1;
                step(P_H, 1'b0, 1'($urandom), 1'($urandom), $urandom);
                return;
            end
`endif
            step(P_F, i == iw, 1'($urandom), 1'($urandom), ins);
        end
        ir_m = ins;
        step(P_D, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
        if (ins == 32'hFFFFFFFF) begin h_m = 1; return; end
        if (!(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                         7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011})) begin
            h_m = 1; ill_m = 1; return;
        end
        step(P_E, 1'($urandom), 1'($urandom), z, $urandom);
        if (op == 7'b1100011) return;
        if (op == 7'b0000011 || op == 7'b0100011) begin
            for (int j = 0; j <= dw; j++) begin
`ifdef CU_WATCHDOG_EN
                if (j == TMO) begin
                    h_m = 1; to_m = 1;
                    step(P_H, 1'($urandom), 1'b0, 1'($urandom), $urandom);
                    return;
                end
`endif
                step(P_M, 1'($urandom), j == dw, 1'($urandom), $urandom);
            end
            if (op == 7'b0100011) return;
        end
        step(P_W, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(8);
        r[6:0] = ops[k];
        if (k == 4) r[14:12] = brf[$urandom_range(5)];
        if (k == 8) r[31:25] = {1'b0, r[30], 5'b0};
        return r;
    endfunction

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++)
            step(P_H, i[0], 1'($urandom), 1'($urandom), $urandom);
    endtask

    initial begin
        bus.RST = 1'b1; bus.ihit = 0; bus.dhit = 0; bus.zero = 0; bus.imemload = '0;
        @(posedge clk); #1;
        do_reset();

        // store stalled in MEM, then aborted by an asynchronous reset
        step(P_F, 1'b1, 1'b0, 1'b0, 32'h0020A223);
        ir_m = 32'h0020A223;
        step(P_D, 1'b0, 1'b0, 1'b0, 32'h0);
        step(P_E, 1'b0, 1'b0, 1'b0, 32'h0);
        step(P_M, 1'b0, 1'b0, 1'b0, 32'h0);
        bus.dhit = 0; #2;
        bus.RST = 1'b1; #1;
        chk("async_rst_out", {12'd0, actv()}, 32'd0);
        chk("async_rst_instr", bus.instr, 32'd0);
        do_reset();

        run_instr(32'h002081B3, 0, 0, 1'b0);  // add x3,x1,x2
        run_instr(32'h0040A283, 0, 3, 1'b0);  // lw x5,4(x1) with late dhit
        run_instr(32'h00209463, 0, 0, 1'b0);  // bne taken
        run_instr(32'h00209463, 1, 0, 1'b1);  // bne not taken

        for (int n = 0; n < 300; n++)
            run_instr(rand_instr(), $urandom_range(3), $urandom_range(3), 1'($urandom));

        run_instr(32'hFFFFFFFF, 0, 0, 1'b0);
        halt_cycles(20);
        do_reset();
        run_instr(32'h0000000B, 2, 0, 1'b0);
        halt_cycles(6);
        do_reset();

`ifdef CU_WATCHDOG_EN
        run_instr(32'h002081B3, TMO, 0, 1'b0);
        halt_cycles(4);
        do_reset();
        run_instr(32'h002081B3, TMO - 1, 0, 1'b0);
        run_instr(32'h0040A283, 0, TMO - 1, 1'b0);
        run_instr(32'h0040A283, 0, TMO, 1'b0);
        halt_cycles(4);
        do_reset();
`endif
        run_instr(32'h002081B3, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequencing control unit for the multicycle RV32I datapath, successor to the single-cycle combinational control decode. It holds the instruction register and a state machine (FETCH/DECODE/EXEC/MEM/WB/HALT). It waits on instruction and data memory handshakes and drives per-state datapath enables plus the decoded control bundle. It sits between the memory arbiter (`ihit`/`dhit`) and the datapath (PC, register file, ALU, muxes). An optional memory watchdog is included.

## Interface
Parameters:
- `WORD_W`, 32: instruction and data word width.
- `TIMEOUT`, 16: watchdog limit in cycles; only used with `CU_WATCHDOG_EN`.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `CLK` in 1: clock.
  - `RST` in 1: asynchronous reset, active-high.
- Memory and ALU inputs:
  - `imemload` in `WORD_W`: instruction from memory.
  - `ihit` in 1: instruction memory ready.
  - `dhit` in 1: data memory ready.
  - `zero` in 1: ALU zero flag.
- Memory requests:
  - `iREN` out 1: instruction read request.
  - `dREN` out 1: data read request.
  - `dWEN` out 1: data write request.
- Datapath enables:
  - `ir_en` out 1: instruction register load.
  - `pc_en` out 1: PC update.
  - `WEN` out 1: register file write.
- Decoded control:
  - `alu_op` out `aluop_t`: ALU operation.
  - `ALUsrc` out 1: 1 selects the immediate.
  - `memtoreg` out 1: 1 selects load data for writeback.
  - `jal`, `jalr`, `auipc`, `lui` out 1 each: writeback and PC mux selects.
  - `branch_taken` out 1: PC takes the branch target.
- Status:
  - `instr` out `WORD_W`: instruction register contents.
  - `halt` out 1: sticky halt.
  - `illegal` out 1: sticky; halt was caused by an unknown opcode.
  - `timeout` out 1: sticky; halt was caused by the watchdog.

## Operation
- **FETCH**
  - `iREN`=1.
  - On `ihit`: `ir_en`=1, `instr` <= `imemload`, go to DECODE.
  - Without `ihit`: stay in FETCH.
- **DECODE**
  - Opcode from `instr[6:0]`.
  - `instr`==32'hFFFFFFFF: go to HALT and set `halt`.
  - Opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ITYPE, RTYPE}: go to HALT and set `halt` and `illegal`.
  - Otherwise go to EXEC.
- **EXEC**
  - Decoded control is valid: `alu_op`, `ALUsrc`, selects.
  - LOAD/STORE: `alu_op`=ADD, `ALUsrc`=1, go to MEM.
  - BRANCH: go to FETCH with `pc_en`=1.
    - BEQ/BNE use SUB; taken = `zero` / !`zero`.
    - BLT/BLTU use SLT/SLTU; taken = !`zero`.
    - BGE/BGEU use SLT/SLTU; taken = `zero`.
  - All other opcodes: go to WB.
- **MEM**
  - LOAD holds `dREN`=1 until `dhit`, then goes to WB with `memtoreg`=1.
  - STORE holds `dWEN`=1 until `dhit`, then goes to FETCH with `pc_en`=1.
  - `dREN` and `dWEN` are never both 1.
- **WB**
  - `WEN`=1 and `pc_en`=1 for one cycle, then go to FETCH.
  - JAL/JALR: `WEN` writes PC+4; PC mux follows `jal`/`jalr`.
- **HALT**
  - Absorbing: every enable and request is 0.
  - `halt` stays 1 until `RST`.
- Decoded control outputs are held constant from DECODE through the end of the instruction.
- In states where a control output is not used, it is 0.
- `branch_taken` is 0 outside EXEC.

## Timing
- While `RST`=1:
  - state = FETCH.
  - `instr`=0, `halt`=`illegal`=`timeout`=0.
  - Every output, including `iREN`, is forced to 0.
- The first `iREN` is asserted in the first cycle after `RST` deasserts.
- State is registered. Enables are a combinational function of the state register and `instr`, so there are no extra cycles.
- Latency with zero-wait memory, counted from the FETCH entry cycle:
  - BRANCH: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle on `ihit` or `dhit` adds one cycle.
- A hit arriving in a cycle where the request is 0 is ignored.
- `RST` asserted mid-instruction aborts it immediately. No `WEN`/`dWEN` is issued after the asynchronous edge.

## Configuration
- `CU_WATCHDOG_EN` defined:
  - A wait counter of width `$clog2(TIMEOUT+1)` counts consecutive cycles in FETCH without `ihit`, or in MEM without `dhit`.
  - The counter clears on each hit and on every state change.
  - When it reaches `TIMEOUT`, the next state is HALT with `halt`=`timeout`=1.
  - A hit in the same cycle as the count reaching `TIMEOUT` wins; no timeout occurs.
- `CU_WATCHDOG_EN` undefined:
  - No counter; the unit waits indefinitely.
  - `timeout` is tied to 0.
  - `TIMEOUT` is unused.

## Structure
- `cpu_types_pkg` holds:
  - `opcode_t` (RV32I opcodes).
  - `funct3` branch codes.
  - `mc_state_t` enum {FETCH, DECODE, EXEC, MEM, WB, HALT}.
  - `HALT_INSTR` = 32'hFFFFFFFF.
  - The existing `aluop_t`.
- `multicycle_control_unit_if` groups the ports, with `cu` and `tb` modports.
- Sub-module `instr_decoder`: combinational map of `instr` to {`alu_op`, `ALUsrc`, `memtoreg`, `jal`, `jalr`, `auipc`, `lui`, branch cond, `illegal`}. The top contains only the FSM, the IR and the watchdog.

## Test plan
- **Reset:** `RST`=1 mid-MEM of a STORE with `dWEN`=1.
  - Expect all outputs 0 immediately, and `iREN`=1 on the first cycle after release.
- **ADD:** `imemload`=32'h002081B3 (add x3,x1,x2), `ihit` immediate.
  - Expect FETCH, DECODE, EXEC, WB.
  - In WB: `WEN`=1, `pc_en`=1, `alu_op`=ADD, `ALUsrc`=0.
  - Next FETCH occurs 4 cycles after the first.
- **LOAD:** lw x5,4(x1) (32'h0040A283) with `dhit` delayed 3 cycles.
  - Expect `dREN`=1 for 4 cycles, then WB with `memtoreg`=1 and `WEN`=1.
  - Total 8 cycles.
- **BNE:** 32'h00209463 with `zero`=0.
  - Expect `branch_taken`=1 and `pc_en`=1 in EXEC, `alu_op`=SUB.
  - Repeat with `zero`=1: expect `branch_taken`=0.
- **Halt and illegal:**
  - 32'hFFFFFFFF: expect `halt`=1, `illegal`=0, sticky through 10 further `ihit` pulses.
  - Opcode 7'b0001011: expect `halt`=`illegal`=1.
- **Watchdog:** `CU_WATCHDOG_EN`, `TIMEOUT`=4, `ihit` held 0.
  - Expect `timeout`=`halt`=1 after 4 FETCH cycles.
  - With `ihit` pulsed exactly on the 4th cycle: expect no timeout.
